uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares the single UART transmit engine (baud generator, tx datapath, tx control path) between several byte producers. It selects one requester, captures its byte, and launches the frame with a one-cycle start pulse. It then tracks the engine's busy flag through the frame and enforces an inter-frame guard gap before arbitrating again. It sits between the producers and the `start`/`data_in` inputs of the UART top.

## Interface
Parameters:
- NREQ, 4 — number of requesters (2..8)
- GAP_CYCLES, 16 — idle clock cycles enforced after each frame or error (0 = none)
- START_TO, 64 — cycles allowed for tx_busy to rise after tx_start before an error is declared

Ports:
- clock  in  1  — single system clock, rising edge
- reset  in  1  — asynchronous, active-high reset
- req  in  NREQ  — request per producer; must be held with stable data until its gnt
- req_data  in  NREQ*8  — byte of requester i at [8i+7:8i]
- gnt  out  NREQ  — one-hot, 1-cycle pulse: byte of that requester captured and launched
- done  out  NREQ  — one-hot, 1-cycle pulse: that requester's frame finished (tx_busy fell)
- err  out  NREQ  — one-hot, 1-cycle pulse: tx_busy never rose within START_TO cycles
- tx_start  out  1  — 1-cycle start pulse to the UART tx control path
- tx_data  out  8  — captured byte, held stable from launch until the next launch
- tx_busy  in  1  — high while the tx engine is sending a frame
- active_id  out  clog2(NREQ)  — index of the current or last granted requester
- idle  out  1  — high only in IDLE

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if |req and tx_busy==0, pick the first set req scanning upward from ptr and wrapping. On that edge: latch tx_data and active_id, set ptr to (winner+1) mod NREQ, go to LAUNCH. If tx_busy==1, stay in IDLE and do not arbitrate.
- LAUNCH (exactly 1 cycle): tx_start=1 and gnt[winner]=1 together. Clear the timeout counter. Go to WAIT_BUSY.
- WAIT_BUSY: tx_busy==1 goes to WAIT_DONE. Otherwise increment the counter. When counter==START_TO-1 with tx_busy still 0, pulse err[winner] and go to GAP.
- WAIT_DONE: tx_busy==0 pulses done[winner] and goes to GAP. There is no frame-length timeout.
- GAP: count GAP_CYCLES cycles, then go to IDLE. With GAP_CYCLES==0, done/err transitions go straight to IDLE.
- req is sampled only in IDLE:
  - A requester that keeps req high after gnt is treated as requesting another frame and is served again after any other pending requesters.
  - To send exactly one byte, a requester drops req within 2 cycles of gnt.
- Requests that drop before being granted are simply skipped. There is no latching of request history.
- Counters are clog2(max(START_TO,GAP_CYCLES))+1 bits wide and saturate; they never wrap.

## Timing
- Reset values: state IDLE, ptr 0, gnt/done/err 0, tx_start 0, tx_data 8'h00, active_id 0, idle 1.
- All outputs are registered.
- Latency: req sampled at edge k produces tx_start and gnt high in cycle k+1.
- Minimum spacing of two tx_start pulses: 1 (LAUNCH) + busy duration + 1 + GAP_CYCLES cycles.
- tx_busy rising during the LAUNCH cycle is sampled in WAIT_BUSY; this is valid.
- tx_busy already low on the first WAIT_BUSY cycle counts toward the timeout.
- Simultaneous requests are resolved purely by ptr. With all requesters held active, grants follow the order 0,1,2,3,0,… after reset.
- Asynchronous reset mid-frame:
  - Immediately returns to the reset values.
  - No done or err pulse is issued for the aborted frame.
  - The tx engine is not informed; it is reset by the same signal.

## Structure
- Shared package `uart_pkg`:
  - State enum `arb_state_t`.
  - Default constants for GAP_CYCLES and START_TO.
  - A `UART_BYTE_W=8` constant.
- One natural sub-module, `rr_pick`: combinational round-robin picker. Inputs are req[NREQ] and ptr; outputs are a one-hot winner, its index, and a valid flag.
- The FSM, counters and capture registers live in `uart_tx_arbiter`.

## Test plan
Benches use NREQ=4, GAP_CYCLES=4, START_TO=8, and model the tx engine as: tx_busy rises 2 cycles after tx_start and stays high 20 cycles.

- Single request: req=4'b0100, byte 8'hA5 → gnt=4'b0100 with tx_start 1 cycle later, tx_data=8'hA5. done[2] pulses 1 cycle after tx_busy falls; idle returns 4 cycles after done.
- Fairness: req=4'b1111 held → gnt order 0,1,2,3,0 with tx_data following each lane's byte. tx_start pulses are exactly 1+2+20+1+4 = 28 cycles apart.
- Pointer wrap: after a grant to 3, req=4'b1001 → next grant is 0, then 3.
- Start timeout: model never raises tx_busy → err[winner] pulses 8 cycles after LAUNCH, no done, GAP, then the next requester is served.
- Busy-blocked arbitration: tx_busy forced high while idle with req=4'b0001 → no gnt until tx_busy falls; gnt follows 1 cycle later.
- Reset mid-frame: assert reset during WAIT_DONE → all outputs at reset values immediately, no done. After release with req=4'b0010, the grant goes to 1 (ptr is 0).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width, arbiter states and default timing.
package uart_pkg;

  localparam int UART_BYTE_W    = 8;
  localparam int GAP_CYCLES_DEF = 16;
  localparam int START_TO_DEF   = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GAP
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req at or above ptr, wrapping; zero latency.
// No state and no backpressure; win_vld is low when no request is set.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IDW-1:0]  win_idx,
  output logic            win_vld
);

  always_comb begin : pick
    int j;
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    // Walk offsets downward so the smallest offset from ptr is written last and wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        win_oh    = '0;
        win_oh[j] = 1'b1;
        win_idx   = IDW'(j);
        win_vld   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART tx engine among NREQ producers: round-robin pick, 1-cycle launch, busy tracking, guard gap.
// gnt/tx_start one cycle after req is sampled in IDLE; no arbitration while tx_busy is high or a frame is in flight.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NREQ       = 4,
  parameter  int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter  int START_TO   = START_TO_DEF,
  localparam int IDW        = $clog2(NREQ)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ*UART_BYTE_W-1:0]   req_data,
  output logic [NREQ-1:0]               gnt,
  output logic [NREQ-1:0]               done,
  output logic [NREQ-1:0]               err,
  output logic                          tx_start,
  output logic [UART_BYTE_W-1:0]        tx_data,
  input  logic                          tx_busy,
  output logic [IDW-1:0]                active_id,
  output logic                          idle
);

  localparam int         CNT_MAX     = (START_TO > GAP_CYCLES) ? START_TO : GAP_CYCLES;
  localparam int         CW          = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] TO_LAST  = CW'(START_TO - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam arb_state_t AFTER_FRAME = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

  arb_state_t             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_sat;
  logic [IDW-1:0]         ptr_q, ptr_d, id_d;
  logic [UART_BYTE_W-1:0] data_d;
  logic [NREQ-1:0]        gnt_d, done_d, err_d, id_oh;
  logic                   start_d;
  logic [NREQ-1:0]        win_oh;
  logic [IDW-1:0]         win_idx;
  logic                   win_vld;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  assign id_oh   = {{(NREQ-1){1'b0}}, 1'b1} << active_id;
  assign cnt_sat = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    id_d    = active_id;
    data_d  = tx_data;
    gnt_d   = '0;
    done_d  = '0;
    err_d   = '0;
    start_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_vld && !tx_busy) begin
          data_d  = req_data[int'(win_idx)*UART_BYTE_W +: UART_BYTE_W];
          id_d    = win_idx;
          ptr_d   = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
          gnt_d   = win_oh;
          start_d = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = id_oh;
          cnt_d   = '0;
          state_d = AFTER_FRAME;
        end else begin
          cnt_d = cnt_sat;
        end
      end
      ST_WAIT_DONE: begin
        // No frame-length limit: the engine owns the frame until busy drops.
        if (!tx_busy) begin
          done_d  = id_oh;
          cnt_d   = '0;
          state_d = AFTER_FRAME;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) state_d = ST_IDLE;
        else                   cnt_d   = cnt_sat;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      active_id <= '0;
      tx_data   <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      tx_start  <= 1'b0;
      idle      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      active_id <= id_d;
      tx_data   <= data_d;
      gnt       <= gnt_d;
      done      <= done_d;
      err       <= err_d;
      tx_start  <= start_d;
      idle      <= (state_d == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: expected grants queued as requests are raised, compared as grants appear.
module tb_uart_tx_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [31:0] req_data;
  logic [3:0] gnt, done, err;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [1:0] active_id;
  logic       idle;

  uart_tx_arbiter #(.NREQ(4), .GAP_CYCLES(4), .START_TO(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .active_id (active_id),
    .idle      (idle)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Engine model: busy from 2 to 21 cycles after the launch cycle.
  int   launch_cyc = -1000;
  logic eng_en     = 1'b1;
  logic force_busy = 1'b0;
  assign tx_busy = force_busy | (eng_en && (cyc >= launch_cyc + 2) && (cyc < launch_cyc + 22));

  // A lane requests while it has more frames issued than granted.
  int issued[4]  = '{default: 0};
  int granted[4] = '{default: 0};
  always_comb begin
    req = '0;
    for (int i = 0; i < 4; i++) req[i] = (issued[i] > granted[i]);
  end

  typedef struct {
    int       lane;
    logic [7:0] dat;
  } exp_t;
  exp_t exp_q[$];

  int   pass_cnt = 0, chk_cnt = 0;
  int   n_gnt = 0, n_done = 0, n_err = 0;
  int   gnt_cyc = 0, done_cyc = 0, err_cyc = 0, idle_rise = 0, cur_lane = 0;
  logic idle_prev = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  task automatic sample();
    exp_t e;
    if (reset) begin
      launch_cyc = -1000;
      idle_prev  = 1'b1;
    end else begin
      if (tx_start && eng_en) launch_cyc = cyc;
      if (gnt != 4'b0) begin
        n_gnt++;
        gnt_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("gnt_unexpected", 32'(gnt), 32'h0);
        end else begin
          e = exp_q.pop_front();
          cur_lane = e.lane;
          chk("gnt_lane", 32'(gnt), 32'(1) << e.lane);
          chk("gnt_with_start", 32'(tx_start), 32'h1);
          chk("gnt_data", 32'(tx_data), 32'(e.dat));
          chk("gnt_active_id", 32'(active_id), 32'(e.lane));
          granted[e.lane]++;
        end
      end else if (tx_start) begin
        chk("start_without_gnt", 32'(tx_start), 32'h0);
      end
      if (done != 4'b0) begin
        n_done++;
        done_cyc = cyc;
        chk("done_lane", 32'(done), 32'(1) << cur_lane);
      end
      if (err != 4'b0) begin
        n_err++;
        err_cyc = cyc;
        chk("err_lane", 32'(err), 32'(1) << cur_lane);
      end
      if (idle && !idle_prev) idle_rise = cyc;
      idle_prev = idle;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      sample();
      @(posedge clock);
      #1;
    end
  endtask

  function automatic int ev_count(input int kind);
    case (kind)
      0:       return n_gnt;
      1:       return n_done;
      default: return n_err;
    endcase
  endfunction

  task automatic wait_ev(input int kind, input int target, input int budget);
    int b = 0;
    while (ev_count(kind) < target && b < budget) begin
      tick(1);
      b++;
    end
    if (ev_count(kind) < target) chk("wait_timeout", 32'(ev_count(kind)), 32'(target));
  endtask

  task automatic send(input int lane, input logic [7:0] b, input int frames);
    req_data[lane*8 +: 8] = b;
    for (int f = 0; f < frames; f++) exp_q.push_back('{lane: lane, dat: b});
    issued[lane] += frames;
  endtask

  int t0, g0, base, dbase, ebase, last;

  initial begin
    reset    = 1'b1;
    req_data = '0;
    tick(2);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_done_err", 32'({done, err}), 32'h0);
    chk("rst_tx_start", 32'(tx_start), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_active_id", 32'(active_id), 32'h0);
    chk("rst_idle", 32'(idle), 32'h1);
    reset = 1'b0;
    tick(2);

    // Single request on lane 2.
    send(2, 8'hA5, 1);
    t0 = cyc;
    wait_ev(0, 1, 20);
    chk("req_to_gnt", 32'(gnt_cyc - t0), 32'd1);
    wait_ev(1, 1, 60);
    chk("gnt_to_done", 32'(done_cyc - gnt_cyc), 32'd23);
    chk("tx_data_held", 32'(tx_data), 32'hA5);
    tick(6);
    chk("done_to_idle", 32'(idle_rise - done_cyc), 32'd4);

    // Fairness from reset: all lanes, lane 0 asks twice.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    base  = n_gnt;
    dbase = n_done;
    send(0, 8'h11, 1);
    send(1, 8'h22, 1);
    send(2, 8'h33, 1);
    send(3, 8'h44, 1);
    send(0, 8'h11, 1);
    for (int k = 1; k <= 5; k++) begin
      wait_ev(0, base + k, 60);
      if (k > 1) chk("start_spacing", 32'(gnt_cyc - last), 32'd28);
      last = gnt_cyc;
    end
    wait_ev(1, dbase + 5, 60);

    // Pointer wrap: grant 3, then 0 and 3 pending -> 0 before 3.
    base  = n_gnt;
    dbase = n_done;
    send(3, 8'h3C, 1);
    wait_ev(0, base + 1, 40);
    send(0, 8'hC0, 1);
    send(3, 8'hC3, 1);
    wait_ev(0, base + 3, 120);
    wait_ev(1, dbase + 3, 60);
    tick(8);

    // Start timeout: engine never goes busy.
    eng_en = 1'b0;
    base   = n_gnt;
    dbase  = n_done;
    ebase  = n_err;
    send(1, 8'h77, 1);
    send(2, 8'h88, 1);
    wait_ev(0, base + 1, 20);
    g0 = gnt_cyc;
    wait_ev(2, ebase + 1, 30);
    chk("launch_to_err", 32'(err_cyc - g0), 32'd9);
    wait_ev(0, base + 2, 30);
    chk("err_to_next_gnt", 32'(gnt_cyc - err_cyc), 32'd5);
    wait_ev(2, ebase + 2, 30);
    chk("no_done_on_timeout", 32'(n_done), 32'(dbase));
    tick(8);
    eng_en = 1'b1;

    // Busy-blocked arbitration.
    force_busy = 1'b1;
    base = n_gnt;
    send(0, 8'h5A, 1);
    tick(10);
    chk("blocked_no_gnt", 32'(n_gnt), 32'(base));
    chk("blocked_idle", 32'(idle), 32'h1);
    force_busy = 1'b0;
    t0 = cyc;
    wait_ev(0, base + 1, 20);
    chk("unblock_to_gnt", 32'(gnt_cyc - t0), 32'd1);
    wait_ev(1, n_done + 1, 60);
    tick(8);

    // Reset in the middle of a frame.
    base = n_gnt;
    send(3, 8'h99, 1);
    wait_ev(0, base + 1, 20);
    tick(10);
    chk("mid_frame_busy", 32'({idle, tx_busy}), 32'h1);
    dbase = n_done;
    reset = 1'b1;
    #1;
    chk("arst_gnt_start", 32'({gnt, tx_start}), 32'h0);
    chk("arst_tx_data", 32'(tx_data), 32'h0);
    chk("arst_active_id", 32'(active_id), 32'h0);
    chk("arst_idle", 32'(idle), 32'h1);
    chk("arst_done_err", 32'({done, err}), 32'h0);
    tick(3);
    reset = 1'b0;
    tick(30);
    chk("no_done_after_abort", 32'(n_done), 32'(dbase));
    base = n_gnt;
    send(1, 8'h42, 1);
    wait_ev(0, base + 1, 20);
    wait_ev(1, dbase + 1, 60);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
